// File: rtl/j1_uart_io_if.sv
// J1 I/O bus bundle for the UART peripheral: write strobe, address, write data and read data.
// The master side is the J1 core; the slave side is the peripheral.
interface j1_uart_io_if;
    logic        io_wr;
    logic [15:0] mem_addr;
    logic [15:0] dout;
    logic [15:0] io_din;

    modport master (output io_wr, output mem_addr, output dout, input io_din);
    modport slave  (input io_wr, input mem_addr, input dout, output io_din);
endinterface

// File: rtl/j1_uart_io.sv
// Memory-mapped 8N1 UART for the J1 core: DATA / STATUS / DIV registers decoded on mem_addr[15:12].
// Reads return data selected by the address registered on the previous edge.
module j1_uart_io #(
    parameter logic [15:0] DIV_INIT = 16'd217
) (
    input  logic        clk,
    input  logic        resetq,
    j1_uart_io_if.slave bus,
    input  logic        uart_rx,
    output logic        uart_tx
);

    localparam logic [3:0] ADDR_DATA = 4'h1;
    localparam logic [3:0] ADDR_STAT = 4'h2;
    localparam logic [3:0] ADDR_DIV  = 4'h3;

    typedef enum logic [1:0] {TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3} rx_state_t;

    logic [3:0]  addr_r;
    logic [15:0] div_r;
    logic [15:0] div_eff_s;
    logic [15:0] io_din_s;
    logic        wr_data_s, wr_stat_s, wr_div_s, rx_clr_s;
    logic        unused_s;

    tx_state_t   tx_state_r, tx_state_n;
    logic [15:0] tx_cnt_r, tx_cnt_n;
    logic [2:0]  tx_bit_r, tx_bit_n;
    logic [7:0]  tx_shift_r, tx_shift_n;
    logic        uart_tx_r, uart_tx_n;
    logic        tx_busy_s;

    logic        rx_meta_r, rx_sync_r, rx_prev_r;
    logic        rx_fall_s;
    rx_state_t   rx_state_r, rx_state_n;
    logic [15:0] rx_cnt_r, rx_cnt_n;
    logic [2:0]  rx_bit_r, rx_bit_n;
    logic [7:0]  rx_shift_r, rx_shift_n;
    logic [7:0]  rx_data_r, rx_data_n;
    logic        rx_valid_r, rx_valid_n;
    logic        rx_set_s;

    assign unused_s  = ^bus.mem_addr[11:0];
    assign wr_data_s = bus.io_wr && (bus.mem_addr[15:12] == ADDR_DATA);
    assign wr_stat_s = bus.io_wr && (bus.mem_addr[15:12] == ADDR_STAT);
    assign wr_div_s  = bus.io_wr && (bus.mem_addr[15:12] == ADDR_DIV);
    assign rx_clr_s  = wr_stat_s && bus.dout[1];
    // Divisors below 2 would leave no room for a half-bit start sample.
    assign div_eff_s = (div_r < 16'd2) ? 16'd2 : div_r;
    assign tx_busy_s = (tx_state_r != TX_IDLE);
    assign rx_fall_s = rx_prev_r && !rx_sync_r;
    assign uart_tx   = uart_tx_r;
    assign bus.io_din = io_din_s;

    // Read-data mux driven by the previous cycle's address.
    always_comb begin
        io_din_s = 16'h0000;
        case (addr_r)
            ADDR_DATA: io_din_s = {8'h00, rx_data_r};
            ADDR_STAT: io_din_s = {14'd0, rx_valid_r, tx_busy_s};
            ADDR_DIV:  io_din_s = div_r;
            default:   io_din_s = 16'h0000;
        endcase
    end

    // Address pipeline, divisor register and rx synchronizer.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            addr_r    <= 4'h0;
            div_r     <= DIV_INIT;
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            addr_r    <= bus.mem_addr[15:12];
            div_r     <= wr_div_s ? bus.dout : div_r;
            rx_meta_r <= uart_rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // TX next-state: each bit counter is reloaded at a boundary, so DIV changes land there.
    always_comb begin
        tx_state_n = tx_state_r;
        tx_cnt_n   = tx_cnt_r;
        tx_bit_n   = tx_bit_r;
        tx_shift_n = tx_shift_r;
        uart_tx_n  = uart_tx_r;
        case (tx_state_r)
            TX_IDLE: begin
                uart_tx_n = 1'b1;
                if (wr_data_s) begin
                    tx_state_n = TX_START;
                    tx_cnt_n   = div_eff_s - 16'd1;
                    tx_shift_n = bus.dout[7:0];
                    uart_tx_n  = 1'b0;
                end else begin
                    tx_state_n = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_cnt_r == 16'd0) begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = div_eff_s - 16'd1;
                    tx_bit_n   = 3'd0;
                    uart_tx_n  = tx_shift_r[0];
                end else begin
                    tx_cnt_n   = tx_cnt_r - 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_r == 16'd0) begin
                    tx_cnt_n = div_eff_s - 16'd1;
                    if (tx_bit_r == 3'd7) begin
                        tx_state_n = TX_STOP;
                        uart_tx_n  = 1'b1;
                    end else begin
                        tx_bit_n   = tx_bit_r + 3'd1;
                        tx_shift_n = {1'b0, tx_shift_r[7:1]};
                        uart_tx_n  = tx_shift_r[1];
                    end
                end else begin
                    tx_cnt_n = tx_cnt_r - 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_r == 16'd0) begin
                    tx_state_n = TX_IDLE;
                    uart_tx_n  = 1'b1;
                end else begin
                    tx_cnt_n   = tx_cnt_r - 16'd1;
                end
            end
            default: begin
                tx_state_n = TX_IDLE;
                uart_tx_n  = 1'b1;
            end
        endcase
    end

    // TX state register.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= 16'd0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            uart_tx_r  <= 1'b1;
        end else begin
            tx_state_r <= tx_state_n;
            tx_cnt_r   <= tx_cnt_n;
            tx_bit_r   <= tx_bit_n;
            tx_shift_r <= tx_shift_n;
            uart_tx_r  <= uart_tx_n;
        end
    end

    // RX next-state: start bit checked at half a bit, then one sample per bit centre.
    always_comb begin
        rx_state_n = rx_state_r;
        rx_cnt_n   = rx_cnt_r;
        rx_bit_n   = rx_bit_r;
        rx_shift_n = rx_shift_r;
        rx_data_n  = rx_data_r;
        rx_set_s   = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                if (rx_fall_s) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = (div_eff_s >> 1) - 16'd1;
                end else begin
                    rx_state_n = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_r == 16'd0) begin
                    if (rx_sync_r) begin
                        rx_state_n = RX_IDLE;
                    end else begin
                        rx_state_n = RX_DATA;
                        rx_cnt_n   = div_eff_s - 16'd1;
                        rx_bit_n   = 3'd0;
                    end
                end else begin
                    rx_cnt_n = rx_cnt_r - 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_r == 16'd0) begin
                    rx_shift_n = {rx_sync_r, rx_shift_r[7:1]};
                    rx_cnt_n   = div_eff_s - 16'd1;
                    if (rx_bit_r == 3'd7) begin
                        rx_state_n = RX_STOP;
                    end else begin
                        rx_bit_n   = rx_bit_r + 3'd1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt_r - 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_r == 16'd0) begin
                    rx_state_n = RX_IDLE;
                    if (rx_sync_r) begin
                        rx_data_n = rx_shift_r;
                        rx_set_s  = 1'b1;
                    end else begin
                        rx_data_n = rx_data_r;
                    end
                end else begin
                    rx_cnt_n = rx_cnt_r - 16'd1;
                end
            end
            default: begin
                rx_state_n = RX_IDLE;
            end
        endcase
        // A completing frame takes priority over a simultaneous clear.
        if (rx_set_s) begin
            rx_valid_n = 1'b1;
        end else if (rx_clr_s) begin
            rx_valid_n = 1'b0;
        end else begin
            rx_valid_n = rx_valid_r;
        end
    end

    // RX state register.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= 16'd0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
        end else begin
            rx_state_r <= rx_state_n;
            rx_cnt_r   <= rx_cnt_n;
            rx_bit_r   <= rx_bit_n;
            rx_shift_r <= rx_shift_n;
            rx_data_r  <= rx_data_n;
            rx_valid_r <= rx_valid_n;
        end
    end

endmodule

// File: tb/tb_j1_uart_io.sv
// Directed bench for j1_uart_io: register map, TX framing, RX reception, error cases and reset.
module tb_j1_uart_io;

    localparam logic [15:0] A_DATA = 16'h1000;
    localparam logic [15:0] A_STAT = 16'h2000;
    localparam logic [15:0] A_DIV  = 16'h3000;
    localparam int          RXDIV  = 8;

    logic clk;
    logic resetq;
    logic uart_rx;
    logic uart_tx;
    int   n_checks;
    int   n_fail;

    j1_uart_io_if bus_if ();

    j1_uart_io #(.DIV_INIT(16'd217)) dut (
        .clk     (clk),
        .resetq  (resetq),
        .bus     (bus_if),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
        @(negedge clk);
        bus_if.io_wr    = 1'b1;
        bus_if.mem_addr = addr;
        bus_if.dout     = data;
        @(negedge clk);
        bus_if.io_wr    = 1'b0;
        bus_if.mem_addr = A_STAT;
    endtask

    task automatic do_read(input logic [15:0] addr, output logic [15:0] val);
        @(negedge clk);
        bus_if.mem_addr = addr;
        @(negedge clk);
        val = bus_if.io_din;
    endtask

    // Drive one 8N1 frame at RXDIV clocks per bit; optional clear write sampled on edge clr_at+1.
    task automatic send_rx(input logic [7:0] data, input logic stop, input int clr_at);
        for (int i = 0; i < 10 * RXDIV; i++) begin
            @(negedge clk);
            if (i / RXDIV == 0)      uart_rx = 1'b0;
            else if (i / RXDIV == 9) uart_rx = stop;
            else                     uart_rx = data[i / RXDIV - 1];
            if (i == clr_at) begin
                bus_if.io_wr    = 1'b1;
                bus_if.mem_addr = A_STAT;
                bus_if.dout     = 16'h0002;
            end else begin
                bus_if.io_wr    = 1'b0;
            end
        end
        @(negedge clk);
        uart_rx      = 1'b1;
        bus_if.io_wr = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        #12;
        n_checks++;
        if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", uart_tx); end
        n_checks++;
        if (bus_if.io_din !== 16'h0000) begin n_fail++; $display("FAIL reset_din got %h want 0000", bus_if.io_din); end
        @(negedge clk);
        resetq = 1'b1;
        do_read(A_STAT, v);
        n_checks++;
        if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_status got %h want 0000", v); end
        do_read(A_DIV, v);
        n_checks++;
        if (v !== 16'd217) begin n_fail++; $display("FAIL reset_div got %h want 00d9", v); end
        do_read(A_DATA, v);
        n_checks++;
        if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_data got %h want 0000", v); end
        do_read(16'h4123, v);
        n_checks++;
        if (v !== 16'h0000) begin n_fail++; $display("FAIL unmapped_4 got %h want 0000", v); end
        do_read(16'hF000, v);
        n_checks++;
        if (v !== 16'h0000) begin n_fail++; $display("FAIL unmapped_f got %h want 0000", v); end
    endtask

    task automatic test_div_clamp();
        logic [15:0] v;
        logic [2:0]  exp_tx;
        exp_tx = 3'b100;
        do_write(A_DIV, 16'h0001);
        do_read(A_DIV, v);
        n_checks++;
        if (v !== 16'h0001) begin n_fail++; $display("FAIL div_readback got %h want 0001", v); end
        @(negedge clk);
        bus_if.io_wr    = 1'b1;
        bus_if.mem_addr = A_DATA;
        bus_if.dout     = 16'h00FF;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            bus_if.io_wr    = 1'b0;
            bus_if.mem_addr = A_STAT;
            n_checks++;
            if (uart_tx !== exp_tx[j]) begin n_fail++; $display("FAIL div_clamp_bit%0d got %b want %b", j, uart_tx, exp_tx[j]); end
        end
        repeat (30) @(negedge clk);
        n_checks++;
        if (bus_if.io_din !== 16'h0000) begin n_fail++; $display("FAIL div_clamp_done got %h want 0000", bus_if.io_din); end
    endtask

    task automatic test_tx();
        logic [9:0] exp_seq;
        int         stray;
        exp_seq = 10'b11_0100_1010;
        do_write(A_DIV, 16'h0004);
        @(negedge clk);
        bus_if.io_wr    = 1'b1;
        bus_if.mem_addr = A_DATA;
        bus_if.dout     = 16'h00A5;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (j == 0) begin
                bus_if.io_wr    = 1'b0;
                bus_if.mem_addr = A_STAT;
            end
            if (j == 10) begin
                bus_if.io_wr    = 1'b1;
                bus_if.mem_addr = A_DATA;
                bus_if.dout     = 16'h005A;
            end
            if (j == 11) begin
                bus_if.io_wr    = 1'b0;
                bus_if.mem_addr = A_STAT;
            end
            n_checks++;
            if (uart_tx !== exp_seq[j / 4]) begin
                n_fail++; $display("FAIL tx_bit clk %0d got %b want %b", j, uart_tx, exp_seq[j / 4]);
            end
            if (j != 0 && j != 11) begin
                n_checks++;
                if (bus_if.io_din !== 16'h0001) begin n_fail++; $display("FAIL tx_busy clk %0d got %h want 0001", j, bus_if.io_din); end
            end
        end
        @(negedge clk);
        n_checks++;
        if (bus_if.io_din !== 16'h0000) begin n_fail++; $display("FAIL tx_idle_status got %h want 0000", bus_if.io_din); end
        stray = 0;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) stray++;
        end
        n_checks++;
        if (stray !== 0) begin n_fail++; $display("FAIL tx_no_second_frame got %0d low clocks want 0", stray); end
    endtask

    task automatic test_rx();
        logic [15:0] v;
        do_write(A_DIV, 16'h0008);
        send_rx(8'h3C, 1'b1, -1);
        do_read(A_STAT, v);
        n_checks++;
        if (v !== 16'h0002) begin n_fail++; $display("FAIL rx_status got %h want 0002", v); end
        do_read(A_DATA, v);
        n_checks++;
        if (v !== 16'h003C) begin n_fail++; $display("FAIL rx_data got %h want 003c", v); end
        do_write(A_STAT, 16'h0001);
        do_read(A_STAT, v);
        n_checks++;
        if (v !== 16'h0002) begin n_fail++; $display("FAIL rx_clear_bit0 got %h want 0002", v); end
        do_write(A_STAT, 16'h0002);
        do_read(A_STAT, v);
        n_checks++;
        if (v !== 16'h0000) begin n_fail++; $display("FAIL rx_clear got %h want 0000", v); end
        send_rx(8'hC3, 1'b1, -1);
        send_rx(8'h5A, 1'b1, -1);
        do_read(A_DATA, v);
        n_checks++;
        if (v !== 16'h005A) begin n_fail++; $display("FAIL rx_back_to_back got %h want 005a", v); end
    endtask

    task automatic test_glitch();
        logic [15:0] v;
        do_write(A_STAT, 16'h0002);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (100) @(negedge clk);
        do_read(A_STAT, v);
        n_checks++;
        if (v !== 16'h0000) begin n_fail++; $display("FAIL rx_glitch got %h want 0000", v); end
    endtask

    task automatic test_rx_errors();
        logic [15:0] v;
        send_rx(8'h3C, 1'b1, -1);
        send_rx(8'h55, 1'b0, -1);
        repeat (4) @(negedge clk);
        do_read(A_STAT, v);
        n_checks++;
        if (v !== 16'h0002) begin n_fail++; $display("FAIL framing_keep_valid got %h want 0002", v); end
        do_read(A_DATA, v);
        n_checks++;
        if (v !== 16'h003C) begin n_fail++; $display("FAIL framing_keep_data got %h want 003c", v); end
        do_write(A_STAT, 16'h0002);
        send_rx(8'hAA, 1'b0, -1);
        repeat (4) @(negedge clk);
        do_read(A_STAT, v);
        n_checks++;
        if (v !== 16'h0000) begin n_fail++; $display("FAIL framing_no_set got %h want 0000", v); end
        bus_if.mem_addr = A_STAT;
        send_rx(8'h81, 1'b1, 10 * RXDIV - 2);
        do_read(A_STAT, v);
        n_checks++;
        if (v !== 16'h0002) begin n_fail++; $display("FAIL set_beats_clear got %h want 0002", v); end
        do_read(A_DATA, v);
        n_checks++;
        if (v !== 16'h0081) begin n_fail++; $display("FAIL set_beats_clear_data got %h want 0081", v); end
    endtask

    task automatic test_reset_mid_tx();
        logic [15:0] v;
        do_write(A_DIV, 16'h0004);
        @(negedge clk);
        bus_if.io_wr    = 1'b1;
        bus_if.mem_addr = A_DATA;
        bus_if.dout     = 16'h00A5;
        @(negedge clk);
        bus_if.io_wr    = 1'b0;
        bus_if.mem_addr = A_DIV;
        repeat (9) @(negedge clk);
        n_checks++;
        if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL mid_tx_low got %b want 0", uart_tx); end
        #2 resetq = 1'b0;
        #1;
        n_checks++;
        if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_abort_tx got %b want 1", uart_tx); end
        n_checks++;
        if (bus_if.io_din !== 16'h0000) begin n_fail++; $display("FAIL reset_abort_din got %h want 0000", bus_if.io_din); end
        @(negedge clk);
        resetq = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus_if.io_din !== 16'd217) begin n_fail++; $display("FAIL reset_div_init got %h want 00d9", bus_if.io_din); end
        do_read(A_STAT, v);
        n_checks++;
        if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_status_after got %h want 0000", v); end
    endtask

    initial begin
        clk             = 1'b0;
        resetq          = 1'b0;
        uart_rx         = 1'b1;
        bus_if.io_wr    = 1'b0;
        bus_if.mem_addr = 16'h0000;
        bus_if.dout     = 16'h0000;
        n_checks        = 0;
        n_fail          = 0;
        test_reset();
        test_div_clamp();
        test_tx();
        test_rx();
        test_glitch();
        test_rx_errors();
        test_reset_mid_tx();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
